// File: rtl/midi_uart_rx_pkg.sv
// Shared types and constants for the MIDI IN receiver and its baud-tick divider.
// The divider rounding helper is kept here so the planned MIDI OUT side derives the same rate.
package midi_uart_rx_pkg;

   typedef enum logic [1:0] {
      URX_IDLE,
      URX_START,
      URX_DATA,
      URX_STOP
   } uart_rx_state_t;

   localparam int MIDI_BAUD      = 31250;
   localparam int MIDI_SYSCLK    = 21477270;
   localparam int URX_OVERSAMPLE = 16;

   // Sample-counter positions used for the three-sample majority vote
   localparam logic [3:0] URX_S_VOTE_A = 4'd7;
   localparam logic [3:0] URX_S_VOTE_B = 4'd8;
   localparam logic [3:0] URX_S_DECIDE = 4'd9;

   function automatic int baud_div(input int clk_hz, input int baud, input int os);
      return (clk_hz + (baud * os) / 2) / (baud * os);
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/midi_uart_rx_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clk_sys cycles.
// restart realigns the tick phase so the first tick lands DIV cycles later.
module uart_baud_tick
   import midi_uart_rx_pkg::*;
#(
   parameter int sysCLK     = MIDI_SYSCLK,
   parameter int BAUD       = MIDI_BAUD,
   parameter int OVERSAMPLE = URX_OVERSAMPLE
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int DIV   = baud_div(sysCLK, BAUD, OVERSAMPLE);
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_tc;

   assign w_tc = (r_cnt == '0);
   assign tick = w_tc;

   always_ff @(posedge clk_sys) begin
      if (reset || restart) begin
         r_cnt <= RELOAD;
      end else if (w_tc) begin
         r_cnt <= RELOAD;
      end else begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI IN 8N1 receiver: 2-FF synchroniser, 16x oversampling, 7/8/9 majority vote,
// byte presented with a one-cycle uart_rx strobe, bad stop bit flagged with frame_error.
//
//  state     | meaning
//  URX_IDLE  | waiting for a 1->0 edge on the synced line
//  URX_START | validating the start bit (glitch rejection)
//  URX_DATA  | shifting in 8 data bits, LSB first
//  URX_STOP  | checking the stop bit, then strobe byte or error
module midi_uart_rx
   import midi_uart_rx_pkg::*;
#(
   parameter int sysCLK     = MIDI_SYSCLK,
   parameter int BAUD       = MIDI_BAUD,
   parameter int OVERSAMPLE = URX_OVERSAMPLE
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       rx_enable,
   input  logic       rx_serial,
   output logic [7:0] uart_rx_data,
   output logic       uart_rx,
   output logic       frame_error,
   output logic       busy
);

   uart_rx_state_t r_state;
   uart_rx_state_t w_state_nxt;

   logic [1:0] r_sync;
   logic       r_prev;
   logic [3:0] r_s;
   logic [1:0] r_vote;
   logic [2:0] r_bit_idx;
   logic [7:0] r_shift;
   logic [7:0] r_data;
   logic       r_rx_stb;
   logic       r_ferr;

   logic w_line;
   logic w_tick;
   logic w_start;
   logic w_decide;
   logic w_bit;
   logic w_busy;
   logic w_rx_stb_nxt;
   logic w_ferr_nxt;

   uart_baud_tick #(
      .sysCLK     (sysCLK),
      .BAUD       (BAUD),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_baud_tick (
      .clk_sys (clk_sys),
      .reset   (reset),
      .restart (w_start),
      .tick    (w_tick)
   );

   assign w_line   = r_sync[1];
   assign w_start  = (r_state == URX_IDLE) && rx_enable && r_prev && !w_line;
   assign w_decide = w_tick && (r_s == URX_S_DECIDE);
   assign w_bit    = maj3(r_vote[0], r_vote[1], w_line);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state <= URX_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         URX_IDLE:  if (w_start) w_state_nxt = URX_START;
         URX_START: if (w_decide) w_state_nxt = w_bit ? URX_IDLE : URX_DATA;
         URX_DATA:  if (w_decide && (r_bit_idx == 3'd7)) w_state_nxt = URX_STOP;
         URX_STOP:  if (w_decide) w_state_nxt = URX_IDLE;
         default:   w_state_nxt = URX_IDLE;
      endcase
      if (!rx_enable) begin
         w_state_nxt = URX_IDLE;
      end
   end

   // Strobes are computed here and registered below, so they land one clk after the decision
   always_comb begin
      w_busy       = (r_state != URX_IDLE);
      w_rx_stb_nxt = 1'b0;
      w_ferr_nxt   = 1'b0;
      if ((r_state == URX_STOP) && w_decide && rx_enable) begin
         w_rx_stb_nxt = w_bit;
         w_ferr_nxt   = !w_bit;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_sync    <= 2'b11;
         r_prev    <= 1'b1;
         r_s       <= '0;
         r_vote    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_data    <= '0;
         r_rx_stb  <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         r_sync   <= {r_sync[0], rx_serial};
         r_prev   <= w_line;
         r_rx_stb <= w_rx_stb_nxt;
         r_ferr   <= w_ferr_nxt;
         if (w_rx_stb_nxt) begin
            r_data <= r_shift;
         end
         if (w_start) begin
            r_s       <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
         end else if (w_tick && (r_state != URX_IDLE)) begin
            r_s <= r_s + 1'b1;
            if (r_s == URX_S_VOTE_A) r_vote[0] <= w_line;
            if (r_s == URX_S_VOTE_B) r_vote[1] <= w_line;
            if ((r_s == URX_S_DECIDE) && (r_state == URX_DATA)) begin
               r_shift   <= {w_bit, r_shift[7:1]};
               r_bit_idx <= r_bit_idx + 1'b1;
            end
         end
      end
   end

   assign uart_rx_data = r_data;
   assign uart_rx      = r_rx_stb;
   assign frame_error  = r_ferr;
   assign busy         = w_busy;

endmodule

// File: tb/tb_midi_uart_rx.sv
// Directed bench for midi_uart_rx at default parameters (bit = 688 clk_sys).
module tb_midi_uart_rx;

   localparam int BIT      = 688;
   localparam int IDLE_GAP = 1000;

   logic       clk_sys = 1'b0;
   logic       reset;
   logic       rx_enable;
   logic       rx_serial;
   logic [7:0] uart_rx_data;
   logic       uart_rx;
   logic       frame_error;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int rx_cnt   = 0;
   int ferr_cnt = 0;
   int both_cnt = 0;
   int edge_cyc = 0;
   int strobe_cyc = 0;
   int lat;
   bit busy_seen = 1'b0;
   logic [7:0] rx_q[$];

   midi_uart_rx dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .rx_enable    (rx_enable),
      .rx_serial    (rx_serial),
      .uart_rx_data (uart_rx_data),
      .uart_rx      (uart_rx),
      .frame_error  (frame_error),
      .busy         (busy)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc <= cyc + 1;

   always @(negedge clk_sys) begin
      if (uart_rx === 1'b1) begin
         rx_cnt++;
         rx_q.push_back(uart_rx_data);
         strobe_cyc = cyc;
      end
      if (frame_error === 1'b1) ferr_cnt++;
      if ((uart_rx === 1'b1) && (frame_error === 1'b1)) both_cnt++;
      if (busy === 1'b1) busy_seen = 1'b1;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input logic v, input int n);
      rx_serial = v;
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int bl);
      edge_cyc = cyc;
      hold(1'b0, bl);
      for (int i = 0; i < 8; i++) hold(d[i], bl);
      hold(stop, bl);
      rx_serial = 1'b1;
   endtask

   task automatic send_partial(input logic [7:0] d, input int nbits, input int bl);
      hold(1'b0, bl);
      for (int i = 0; i < nbits; i++) hold(d[i], bl);
      hold(d[nbits], bl / 2);
   endtask

   initial begin
      reset     = 1'b1;
      rx_enable = 1'b1;
      rx_serial = 1'b1;
      repeat (5) @(negedge clk_sys);
      reset = 1'b0;
      @(negedge clk_sys);
      chk("reset_data", uart_rx_data, 8'h00);
      chk("reset_uart_rx", uart_rx, 1'b0);
      chk("reset_frame_error", frame_error, 1'b0);
      chk("reset_busy", busy, 1'b0);
      hold(1'b1, 200);

      send_frame(8'h90, 1'b1, BIT);
      hold(1'b1, IDLE_GAP);
      lat = strobe_cyc - edge_cyc;
      chk("t1_rx_count", rx_cnt, 1);
      chk("t1_data", uart_rx_data, 8'h90);
      chk("t1_no_ferr", ferr_cnt, 0);
      chk("t1_strobe_mid_stop", int'((lat >= 6536) && (lat <= 6700)), 1);

      busy_seen = 1'b0;
      hold(1'b0, 129);
      hold(1'b1, IDLE_GAP);
      chk("t2_busy_pulsed", int'(busy_seen), 1);
      chk("t2_rx_count", rx_cnt, 1);
      chk("t2_no_ferr", ferr_cnt, 0);
      chk("t2_idle", busy, 1'b0);

      send_frame(8'h55, 1'b0, BIT);
      hold(1'b1, IDLE_GAP);
      chk("t3_ferr_count", ferr_cnt, 1);
      chk("t3_rx_count", rx_cnt, 1);
      chk("t3_data_kept", uart_rx_data, 8'h90);

      send_frame(8'h90, 1'b1, BIT);
      send_frame(8'h3C, 1'b1, BIT);
      send_frame(8'h7F, 1'b1, BIT);
      hold(1'b1, IDLE_GAP);
      chk("t4_rx_count", rx_cnt, 4);
      chk("t4_q_size", rx_q.size(), 4);
      if (rx_q.size() == 4) begin
         chk("t4_byte0", rx_q[1], 8'h90);
         chk("t4_byte1", rx_q[2], 8'h3C);
         chk("t4_byte2", rx_q[3], 8'h7F);
      end
      chk("t4_no_new_ferr", ferr_cnt, 1);

      send_partial(8'hA5, 4, BIT);
      reset     = 1'b1;
      rx_serial = 1'b1;
      repeat (3) @(negedge clk_sys);
      reset = 1'b0;
      @(negedge clk_sys);
      chk("t5r_busy", busy, 1'b0);
      chk("t5r_data_reset", uart_rx_data, 8'h00);
      hold(1'b1, IDLE_GAP);
      chk("t5r_no_strobe", rx_cnt, 4);
      chk("t5r_no_ferr", ferr_cnt, 1);
      send_frame(8'h01, 1'b1, BIT);
      hold(1'b1, IDLE_GAP);
      chk("t5r_rx_count", rx_cnt, 5);
      chk("t5r_data", uart_rx_data, 8'h01);

      send_partial(8'hA5, 4, BIT);
      rx_enable = 1'b0;
      rx_serial = 1'b1;
      repeat (2) @(negedge clk_sys);
      chk("t5e_busy", busy, 1'b0);
      hold(1'b1, BIT);
      rx_enable = 1'b1;
      hold(1'b1, BIT);
      chk("t5e_no_strobe", rx_cnt, 5);
      chk("t5e_no_ferr", ferr_cnt, 1);
      chk("t5e_data_kept", uart_rx_data, 8'h01);
      send_frame(8'h01, 1'b1, BIT);
      hold(1'b1, IDLE_GAP);
      chk("t5e_rx_count", rx_cnt, 6);

      send_frame(8'hC3, 1'b1, 668);
      hold(1'b1, IDLE_GAP);
      chk("t6_fast_rx_count", rx_cnt, 7);
      chk("t6_fast_data", uart_rx_data, 8'hC3);
      send_frame(8'hC3, 1'b1, 709);
      hold(1'b1, IDLE_GAP);
      chk("t6_slow_rx_count", rx_cnt, 8);
      chk("t6_slow_data", uart_rx_data, 8'hC3);
      chk("t6_no_ferr", ferr_cnt, 1);
      chk("never_both_strobes", both_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
